// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the master, the RAM slave and their benches.
// Contents: HTRANS / HSIZE / HBURST / HRESP encodings and the master FSM state.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic {
    HBURST_SINGLE = 1'b0,
    HBURST_INCR   = 1'b1
  } hburst_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_DATA,
    ST_DATA,
    ST_ERR
  } mst_state_e;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns one host command (SINGLE or INCR burst, read or
// write) into pipelined AHB address/data phases, honouring wait states and
// the two-cycle ERROR response.
// Ports:
//   HCLK, HREST          clock, async active-high reset
//   cmd_*                host command handshake (valid/ready, write, addr, len, size)
//   wdata, wdata_ready   write beat data, taken on the edge wdata_ready is high
//   rdata, rdata_valid   read beat data, one pulse per OKAY read beat
//   done, error          end-of-command pulses
//   H*                   AHB-Lite master-side bus signals
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_STEP = 1,
  parameter int unsigned LEN_W     = 4
) (
  input  logic             HCLK,
  input  logic             HREST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [2:0]       cmd_size,
  input  logic [31:0]      wdata,
  output logic             wdata_ready,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  output logic             done,
  output logic             error,
  output logic             HSELx,
  output logic [31:0]      HADDR,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic             HBURST,
  output logic [1:0]       HTRANS,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mst_state_e       state_q,  state_d;
  htrans_e          htrans_q, htrans_d;
  hburst_e          hburst_q, hburst_d;
  logic [31:0]      haddr_q,  haddr_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic [31:0]      rdata_q,  rdata_d;
  logic [2:0]       hsize_q,  hsize_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;   // address phases still to complete, incl. current
  logic             hwrite_q, hwrite_d;
  logic             hsel_q,   hsel_d;
  logic             rvld_q,   rvld_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;

  logic data_phase;
  logic addr_take;

  // An ERROR on the pending data phase cancels the overlapping address phase,
  // so it must not count as an address completion.
  assign data_phase = (state_q == ST_ADDR_DATA) || (state_q == ST_DATA);
  assign addr_take  = HREADY && (htrans_q != HTRANS_IDLE) && !(data_phase && HRESP);

  assign cmd_ready   = (state_q == ST_IDLE);
  assign wdata_ready = addr_take && hwrite_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvld_q;
  assign done        = done_q;
  assign error       = err_q;
  assign HSELx       = hsel_q;
  assign HADDR       = haddr_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = hburst_q;
  assign HTRANS      = htrans_q;
  assign HWDATA      = hwdata_q;

  always_comb begin
    state_d  = state_q;
    htrans_d = htrans_q;
    hburst_d = hburst_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    hsize_d  = hsize_q;
    cnt_d    = cnt_q;
    hwrite_d = hwrite_q;
    hsel_d   = hsel_q;
    rvld_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (wdata_ready) hwdata_d = wdata;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d  = ST_ADDR;
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = cmd_addr;
          hwrite_d = cmd_write;
          hsize_d  = cmd_size;
          hburst_d = (cmd_len != '0) ? HBURST_INCR : HBURST_SINGLE;
          hsel_d   = 1'b1;
          cnt_d    = {1'b0, cmd_len} + CNT_ONE;
        end
      end

      ST_ADDR, ST_ADDR_DATA, ST_DATA: begin
        if (data_phase && HRESP) begin
          // First ERROR cycle: drop remaining beats now, finish when HREADY rises.
          // A one-cycle ERROR (protocol violation) is terminated at once.
          htrans_d = HTRANS_IDLE;
          if (HREADY) begin
            state_d = ST_IDLE;
            hsel_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end else if (HREADY) begin
          if (data_phase && !hwrite_q) begin
            rdata_d = HRDATA;
            rvld_d  = 1'b1;
          end
          if (state_q == ST_DATA) begin
            state_d = ST_IDLE;
            hsel_d  = 1'b0;
            done_d  = 1'b1;
          end else if (cnt_q == CNT_ONE) begin
            state_d  = ST_DATA;
            htrans_d = HTRANS_IDLE;
          end else begin
            state_d  = ST_ADDR_DATA;
            htrans_d = HTRANS_SEQ;
            haddr_d  = haddr_q + ADDR_STEP;
            cnt_d    = cnt_q - CNT_ONE;
          end
        end
      end

      ST_ERR: begin
        if (HREADY) begin
          state_d = ST_IDLE;
          hsel_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HREST) begin
    if (HREST) begin
      state_q  <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      hburst_q <= HBURST_SINGLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      hsize_q  <= HSIZE_WORD;
      cnt_q    <= '0;
      hwrite_q <= 1'b0;
      hsel_q   <= 1'b0;
      rvld_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      hburst_q <= hburst_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      hsize_q  <= hsize_d;
      cnt_q    <= cnt_d;
      hwrite_q <= hwrite_d;
      hsel_q   <= hsel_d;
      rvld_q   <= rvld_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small word-indexed RAM slave.
// HREADY/HRESP are driven directly by the stimulus to place wait states and
// ERROR responses exactly.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HREST;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [31:0] wdata, rdata;
  logic        wdata_ready, rdata_valid, done, error;
  logic        HSELx, HWRITE, HBURST, HREADY, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;

  ahb_lite_master #(.ADDR_STEP(1), .LEN_W(4)) dut (
    .HCLK(HCLK), .HREST(HREST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .error(error),
    .HSELx(HSELx), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // RAM slave: captures the address phase, serves/commits the data phase.
  logic [31:0] mem [0:31];
  logic [4:0]  daddr;
  logic        dvld, dwr;
  always @(posedge HCLK or posedge HREST) begin
    if (HREST) begin
      dvld  <= 1'b0;
      dwr   <= 1'b0;
      daddr <= '0;
    end else if (HREADY) begin
      if (dvld && dwr && !HRESP) mem[daddr] <= HWDATA;
      dvld  <= HSELx && HTRANS[1];
      dwr   <= HWRITE;
      daddr <= HADDR[4:0];
    end
  end
  assign HRDATA = dvld ? mem[daddr] : 32'h0;

  // Pulse monitor, sampled away from the active edge.
  int          wr_n = 0;
  int          done_n = 0;
  logic [31:0] rd_q[$];
  logic        rdd_q[$];
  always @(negedge HCLK) begin
    if (wdata_ready) wr_n++;
    if (done) done_n++;
    if (rdata_valid) begin
      rd_q.push_back(rdata);
      rdd_q.push_back(done);
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] l, input logic [2:0] sz);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_size  = sz;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 30) begin
      step();
      n++;
    end
    chk(tag, done, 1'b1);
    @(negedge HCLK);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, r0;
    HREST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_len = '0; cmd_size = 3'b010; wdata = '0; HREADY = 1'b1; HRESP = 1'b0;
    #3;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hsize", HSIZE, 3'b010);
    chk("rst_hsel", HSELx, 1'b0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_pulses", {rdata_valid, done, error}, 3'b000);
    step(); step();
    HREST = 1'b0;
    step();

    // 1: single byte write of 0x2 to address 0
    wdata = 32'h2;
    issue(1'b1, 32'h0, 4'd0, 3'b000);
    chk("t1_htrans", HTRANS, 2'b10);
    chk("t1_hburst", HBURST, 1'b0);
    chk("t1_haddr", HADDR, 32'h0);
    chk("t1_hsize", HSIZE, 3'b000);
    chk("t1_hsel", HSELx, 1'b1);
    chk("t1_wrdy", wdata_ready, 1'b1);
    chk("t1_cmd_ready", cmd_ready, 1'b0);
    step();
    chk("t1_htrans_idle", HTRANS, 2'b00);
    chk("t1_hwdata", HWDATA, 32'h2);
    chk("t1_done_early", done, 1'b0);
    step();
    chk("t1_done", done, 1'b1);
    chk("t1_hsel_off", HSELx, 1'b0);
    chk("t1_ready", cmd_ready, 1'b1);
    chk("t1_mem0", mem[0], 32'h2);

    // 2: 4-beat INCR write 8,9,D,F to 0..3
    w0 = wr_n;
    wdata = 32'h8;
    issue(1'b1, 32'h0, 4'd3, 3'b010);
    chk("t2_b1", {HTRANS, HBURST, HADDR}, {2'b10, 1'b1, 32'h0});
    step(); wdata = 32'h9;
    chk("t2_b2", {HTRANS, HADDR, HWDATA}, {2'b11, 32'h1, 32'h8});
    step(); wdata = 32'hD;
    chk("t2_b3", {HTRANS, HADDR, HWDATA}, {2'b11, 32'h2, 32'h9});
    step(); wdata = 32'hF;
    chk("t2_b4", {HTRANS, HADDR, HWDATA}, {2'b11, 32'h3, 32'hD});
    step();
    chk("t2_last_data", {HTRANS, HWDATA, done}, {2'b00, 32'hF, 1'b0});
    step();
    chk("t2_done", done, 1'b1);
    chk("t2_wrdy_count", wr_n - w0, 4);
    chk("t2_mem", {mem[0], mem[1], mem[2], mem[3]}, 128'h8_00000009_0000000D_0000000F);

    // 3: 3-beat INCR read of 0..2
    r0 = rd_q.size();
    issue(1'b0, 32'h0, 4'd2, 3'b010);
    wait_done("t3_done");
    chk("t3_count", rd_q.size() - r0, 3);
    chk("t3_rd0", rd_q[r0], 32'h8);
    chk("t3_rd1", rd_q[r0+1], 32'h9);
    chk("t3_rd2", rd_q[r0+2], 32'hD);
    chk("t3_done_with_last", rdd_q[r0+2], 1'b1);

    // 4: 3-beat read of 1..3, two wait states on beat 1's data phase
    r0 = rd_q.size();
    issue(1'b0, 32'h1, 4'd2, 3'b010);
    step(); HREADY = 1'b0;
    chk("t4_w0", {HTRANS, HADDR}, {2'b11, 32'h2});
    step();
    chk("t4_w1", {HTRANS, HADDR, HWDATA, rdata_valid}, {2'b11, 32'h2, 32'hF, 1'b0});
    step(); HREADY = 1'b1;
    chk("t4_w2", {HTRANS, HADDR}, {2'b11, 32'h2});
    wait_done("t4_done");
    chk("t4_count", rd_q.size() - r0, 3);
    chk("t4_data", {rd_q[r0], rd_q[r0+1], rd_q[r0+2]}, {32'h9, 32'hD, 32'hF});

    // 5: 4-beat write to 0x10, ERROR on beat 2
    w0 = wr_n;
    d0 = done_n;
    wdata = 32'h11;
    issue(1'b1, 32'h10, 4'd3, 3'b010);
    step(); wdata = 32'h22;
    step(); HRESP = 1'b1; HREADY = 1'b0;
    chk("t5_err1", {HTRANS, HADDR}, {2'b11, 32'h12});
    step(); HREADY = 1'b1;
    chk("t5_idle", {HTRANS, done, HSELx}, {2'b00, 1'b0, 1'b1});
    step(); HRESP = 1'b0;
    chk("t5_done_err", {done, error, cmd_ready, HSELx}, 4'b1110);
    step();
    chk("t5_pulse_end", {done, error, HTRANS}, 4'b0000);
    chk("t5_wrdy_count", wr_n - w0, 2);
    chk("t5_done_count", done_n - d0, 1);
    chk("t5_mem10", mem[16], 32'h11);

    // 6: reset during beat 2 of a 4-beat read, then a single read
    d0 = done_n;
    issue(1'b0, 32'h0, 4'd3, 3'b010);
    step();
    chk("t6_pre", {HTRANS, HADDR}, {2'b11, 32'h1});
    HREST = 1'b1;
    #1;
    chk("t6_async", {HTRANS, HADDR, HSELx, HWRITE, HBURST, HSIZE}, {2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 3'b010});
    chk("t6_ready", cmd_ready, 1'b1);
    step();
    HREST = 1'b0;
    step(); step();
    chk("t6_no_done", done_n - d0, 0);
    r0 = rd_q.size();
    issue(1'b0, 32'h0, 4'd0, 3'b010);
    wait_done("t6_done");
    chk("t6_count", rd_q.size() - r0, 1);
    chk("t6_rd", rd_q[r0], 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
